// File: rtl/byte_bank_writer_pkg.sv
// Shared bank layout for the byte-lane writer and selector: sizes, lane bit ranges, FSM states.
package byte_bank_writer_pkg;

    localparam int BANK_W     = 8;
    localparam int BANK_NSLOT = 8;
    localparam int BANK_SELW  = 4;
    localparam int BANK_BUS_W = BANK_W * (BANK_NSLOT + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bank_state_e;

    // Slot k occupies bits [w*k+w-1 : w*k]; lane 0 is the hardwired-zero lane.
    function automatic int slot_lsb(input int w, input int k);
        return w * k;
    endfunction

    function automatic int slot_msb(input int w, input int k);
        return w * k + w - 1;
    endfunction

endpackage

// File: rtl/byte_bank_writer.sv
// Byte bank writer: valid/ready slot writes plus a sequenced clear engine.
// Optional macro BYTE_BANK_WRCNT_EN adds the wr_cnt accepted-write counter port.
module byte_bank_writer
    import byte_bank_writer_pkg::*;
#(
    parameter int W     = BANK_W,
    parameter int NSLOT = BANK_NSLOT,
    parameter int SELW  = BANK_SELW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    input  logic [SELW-1:0]        sel,
    input  logic [W-1:0]           data_in,
    output logic                   wr_ready,
    output logic                   wr_err,
    input  logic                   clr_req,
    output logic                   busy,
    output logic [W*(NSLOT+1)-1:0] data_out
`ifdef BYTE_BANK_WRCNT_EN
    ,
    output logic [7:0]             wr_cnt
`endif
);

    bank_state_e     state_q, state_d;
    logic [SELW-1:0] idx_q, idx_d;
    logic [W-1:0]    slot_q [1:NSLOT];
    logic [W-1:0]    slot_d [1:NSLOT];
    logic            wr_err_q, wr_err_d;
    logic            accept;
    logic            sel_ok;

    assign wr_ready = (state_q == IDLE);
    assign busy     = (state_q == CLEAR);
    assign wr_err   = wr_err_q;
    assign accept   = wr_valid && wr_ready;
    assign sel_ok   = (sel != '0) && (sel <= SELW'(NSLOT));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        slot_d   = slot_q;
        wr_err_d = accept && !sel_ok;
        case (state_q)
            IDLE: begin
                if (accept && sel_ok) begin
                    for (int k = 1; k <= NSLOT; k++) begin
                        if (sel == SELW'(k)) slot_d[k] = data_in;
                    end
                end
                // A same-cycle write lands first; the clear sweep then zeroes it too.
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = SELW'(1);
                end
            end
            CLEAR: begin
                for (int k = 1; k <= NSLOT; k++) begin
                    if (idx_q == SELW'(k)) slot_d[k] = '0;
                end
                if (idx_q == SELW'(NSLOT)) begin
                    state_d = IDLE;
                    idx_d   = SELW'(1);
                end else begin
                    idx_d = idx_q + SELW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = SELW'(1);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= SELW'(1);
            wr_err_q <= 1'b0;
            for (int k = 1; k <= NSLOT; k++) slot_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_err_q <= wr_err_d;
            slot_q   <= slot_d;
        end
    end

`ifdef BYTE_BANK_WRCNT_EN
    logic [7:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (state_q == IDLE && clr_req) begin
            wr_cnt_d = '0;
        end else if (accept && sel_ok) begin
            wr_cnt_d = wr_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_cnt_q <= '0;
        else     wr_cnt_q <= wr_cnt_d;
    end

    assign wr_cnt = wr_cnt_q;
`endif

    assign data_out[W-1:0] = '0;
    for (genvar k = 1; k <= NSLOT; k++) begin : g_lane
        assign data_out[slot_msb(W, k):slot_lsb(W, k)] = slot_q[k];
    end

endmodule
